// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types and reset constants.
// Used by the fetch unit, its skid FIFO and the bench.
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0060;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DROP  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Blocking I-cache request bus between fetch and the cache.
// The fetch unit is the master.
interface if_fetch_unit_if;

    logic        inst_read;
    logic [31:0] inst_addr;
    logic        inst_resp;
    logic [31:0] inst_rdata;

    modport master (
        output inst_read,
        output inst_addr,
        input  inst_resp,
        input  inst_rdata
    );

    modport slave (
        input  inst_read,
        input  inst_addr,
        output inst_resp,
        output inst_rdata
    );

endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry {pc, inst} skid FIFO feeding the IF/ID register.
// Flush wins over push and pop.
module fetch_skid_fifo
    import if_fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push}
                           - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch initiator: owns the fetch PC, drives the
// I-cache bus and hands {pc, inst} to IF/ID via a skid FIFO.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC =
        if_fetch_unit_pkg::RESET_PC,
    parameter logic [31:0] NOP_INST =
        if_fetch_unit_pkg::NOP_INST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  br_mispredict,
    input  logic [31:0]           br_target,
    if_fetch_unit_if.master       bus,
    output logic                  valid_out,
    output logic [31:0]           pc_out,
    output logic [31:0]           inst_out
);

    import if_fetch_unit_pkg::fetch_entry_t;
    import if_fetch_unit_pkg::fetch_state_e;
    import if_fetch_unit_pkg::FETCH;
    import if_fetch_unit_pkg::DROP;

    fetch_state_e state;
    logic [31:0]  req_pc;
    logic [31:0]  redirect_pc;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t din;
    logic         accept;
    logic         consume;

    // Count only reaches 2 through a response, so this never
    // drops inst_read in the middle of a request.
    assign bus.inst_read = !rst
        && ((state == DROP) || (count != 2'd2));
    assign bus.inst_addr = req_pc;

    assign valid_out = !rst && (count != 2'd0);
    assign pc_out    = valid_out ? head.pc : 32'd0;
    assign inst_out  = valid_out ? head.inst : NOP_INST;

    assign accept  = (state == FETCH) && bus.inst_resp
                  && !br_mispredict;
    assign consume = valid_out && !stall;
    assign din     = '{pc: req_pc, inst: bus.inst_rdata};

    fetch_skid_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (consume),
        .flush (br_mispredict),
        .din   (din),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            req_pc      <= RESET_PC;
            redirect_pc <= RESET_PC;
        end else if (br_mispredict) begin
            // A live request cannot be cancelled: park the
            // target and swallow the stale response in DROP.
            if (bus.inst_read && !bus.inst_resp) begin
                redirect_pc <= br_target;
                state       <= DROP;
            end else begin
                req_pc <= br_target;
                state  <= FETCH;
            end
        end else begin
            unique case (state)
                FETCH: begin
                    if (accept) begin
                        req_pc <= req_pc + 32'd4;
                    end
                end
                DROP: begin
                    if (bus.inst_resp) begin
                        req_pc <= redirect_pc;
                        state  <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: fetch, stall, redirect,
// drop of stale responses, reset mid-request, PC wrap.
module tb_if_fetch_unit;

    import if_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_mispredict = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] inst_out;

    int nvec = 0;
    int nerr = 0;

    if_fetch_unit_if bus ();

    if_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .br_mispredict (br_mispredict),
        .br_target     (br_target),
        .bus           (bus),
        .valid_out     (valid_out),
        .pc_out        (pc_out),
        .inst_out      (inst_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic        resp,
                         input logic [31:0] data,
                         input logic        mp,
                         input logic [31:0] tgt);
        bus.inst_resp  = resp;
        bus.inst_rdata = data;
        br_mispredict  = mp;
        br_target      = tgt;
    endtask

    task automatic do_reset;
        rst   = 1'b1;
        stall = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic chk_out(input string       tag,
                           input logic        v,
                           input logic [31:0] pc,
                           input logic [31:0] inst);
        chk({tag, "_valid"}, valid_out, v);
        chk({tag, "_pc"}, pc_out, pc);
        chk({tag, "_inst"}, inst_out, inst);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        drive(1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        chk("rst_read", bus.inst_read, 0);
        tick();
        chk_out("rst", 0, 32'd0, NOP_INST);
        chk("rst_read2", bus.inst_read, 0);
        rst = 1'b0;
        #1;

        // plain streaming fetch
        chk("s1_read0", bus.inst_read, 1);
        chk("s1_addr0", bus.inst_addr, 32'h60);
        drive(1, 32'h1111_0000, 0, 0);
        tick();
        chk_out("s1_o0", 1, 32'h60, 32'h1111_0000);
        chk("s1_addr1", bus.inst_addr, 32'h64);
        drive(1, 32'h1111_0004, 0, 0);
        tick();
        chk_out("s1_o1", 1, 32'h64, 32'h1111_0004);
        chk("s1_addr2", bus.inst_addr, 32'h68);
        drive(1, 32'h1111_0008, 0, 0);
        tick();
        chk_out("s1_o2", 1, 32'h68, 32'h1111_0008);
        chk("s1_addr3", bus.inst_addr, 32'h6c);
        drive(0, 0, 0, 0);
        tick();
        chk_out("s1_idle", 0, 32'd0, NOP_INST);

        // stall fills the FIFO
        do_reset();
        stall = 1'b1;
        chk("s2_addr0", bus.inst_addr, 32'h60);
        drive(1, 32'hAAAA_0001, 0, 0);
        tick();
        chk_out("s2_o0", 1, 32'h60, 32'hAAAA_0001);
        chk("s2_addr1", bus.inst_addr, 32'h64);
        drive(1, 32'hAAAA_0002, 0, 0);
        tick();
        chk("s2_full_read", bus.inst_read, 0);
        chk_out("s2_full", 1, 32'h60, 32'hAAAA_0001);
        drive(0, 0, 0, 0);
        tick();
        chk("s2_hold_read", bus.inst_read, 0);
        stall = 1'b0;
        tick();
        chk_out("s2_pop1", 1, 32'h64, 32'hAAAA_0002);
        chk("s2_read2", bus.inst_read, 1);
        chk("s2_addr2", bus.inst_addr, 32'h68);
        tick();
        chk("s2_empty", valid_out, 0);
        drive(1, 32'hAAAA_0003, 0, 0);
        tick();
        chk_out("s2_o2", 1, 32'h68, 32'hAAAA_0003);
        drive(0, 0, 0, 0);

        // mispredict during a slow request
        do_reset();
        drive(1, 32'h0000_1060, 0, 0);
        tick();
        chk("s3_addr1", bus.inst_addr, 32'h64);
        drive(0, 0, 1, 32'h200);
        tick();
        chk("s3_drop_valid", valid_out, 0);
        chk("s3_drop_read", bus.inst_read, 1);
        chk("s3_drop_addr", bus.inst_addr, 32'h64);
        drive(0, 0, 0, 0);
        tick();
        chk("s3_wait_addr", bus.inst_addr, 32'h64);
        tick();
        chk("s3_wait_addr2", bus.inst_addr, 32'h64);
        drive(1, 32'hDEAD_0064, 0, 0);
        tick();
        chk("s3_stale_valid", valid_out, 0);
        chk("s3_new_addr", bus.inst_addr, 32'h200);
        drive(1, 32'h0200_0013, 0, 0);
        tick();
        chk_out("s3_o", 1, 32'h200, 32'h0200_0013);
        chk("s3_next", bus.inst_addr, 32'h204);
        drive(0, 0, 0, 0);

        // mispredict with response in same cycle
        do_reset();
        drive(1, 32'h0000_00A0, 0, 0);
        tick();
        chk("s4_addr1", bus.inst_addr, 32'h64);
        stall = 1'b1;
        drive(1, 32'hBAD0_0064, 1, 32'h400);
        tick();
        chk("s4_flush", valid_out, 0);
        chk("s4_read", bus.inst_read, 1);
        chk("s4_addr", bus.inst_addr, 32'h400);
        stall = 1'b0;
        drive(1, 32'hC000_0400, 0, 0);
        tick();
        chk_out("s4_o", 1, 32'h400, 32'hC000_0400);
        drive(0, 0, 0, 0);

        // two mispredicts while dropping
        do_reset();
        drive(0, 0, 1, 32'h300);
        tick();
        chk("s5_drop_addr", bus.inst_addr, 32'h60);
        chk("s5_drop_valid", valid_out, 0);
        drive(0, 0, 1, 32'h500);
        tick();
        chk("s5_drop_addr2", bus.inst_addr, 32'h60);
        drive(1, 32'hDEAD_0060, 0, 0);
        tick();
        chk("s5_new_addr", bus.inst_addr, 32'h500);
        chk("s5_valid", valid_out, 0);
        drive(1, 32'hD000_0500, 0, 0);
        tick();
        chk_out("s5_o", 1, 32'h500, 32'hD000_0500);
        drive(0, 0, 0, 0);

        // reset with a request pending and count=1
        do_reset();
        stall = 1'b1;
        drive(1, 32'hE000_0060, 0, 0);
        tick();
        chk_out("s6_pre", 1, 32'h60, 32'hE000_0060);
        chk("s6_pre_addr", bus.inst_addr, 32'h64);
        drive(0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("s6_rst_read", bus.inst_read, 0);
        tick();
        chk_out("s6_rst", 0, 32'd0, NOP_INST);
        rst   = 1'b0;
        stall = 1'b0;
        #1;
        chk("s6_read", bus.inst_read, 1);
        chk("s6_addr", bus.inst_addr, 32'h60);

        // PC wraps past the top of memory
        do_reset();
        drive(1, 32'hF000_0000, 1, 32'hFFFF_FFFC);
        tick();
        chk("s7_valid", valid_out, 0);
        chk("s7_addr", bus.inst_addr, 32'hFFFF_FFFC);
        drive(1, 32'hF000_00FC, 0, 0);
        tick();
        chk_out("s7_o", 1, 32'hFFFF_FFFC, 32'hF000_00FC);
        chk("s7_wrap", bus.inst_addr, 32'h0);
        drive(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
